// File: rtl/nibble_serial_cla_adder.sv
// Sequential WIDTH-bit two's-complement adder. One SLICE-bit carry-lookahead
// slice is reused per clock, and the inter-slice carry is held in a register.

module nibble_serial_cla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_c,
    output logic [SLICE-1:0] o_s,
    output logic             o_c
);
    logic [SLICE-1:0] w_p;
    logic [SLICE-1:0] w_g;
    logic [SLICE:0]   w_c;
    logic             w_t;

    // Every carry is a flat OR of generate/propagate product terms back to c[0].
    // No carry is computed from the carry below it.
    always_comb begin
        w_p    = i_a ^ i_b;
        w_g    = i_a & i_b;
        w_c    = '0;
        w_t    = 1'b0;
        w_c[0] = i_c;
        for (int i = 0; i < SLICE; i++) begin
            w_t = i_c;
            for (int m = 0; m <= i; m++) w_t = w_t & w_p[m];
            w_c[i+1] = w_t;
            for (int j = 0; j <= i; j++) begin
                w_t = w_g[j];
                for (int m = j + 1; m <= i; m++) w_t = w_t & w_p[m];
                w_c[i+1] = w_c[i+1] | w_t;
            end
        end
    end

    assign o_s = w_p ^ w_c[SLICE-1:0];
    assign o_c = w_c[SLICE];
endmodule

module nibble_serial_cla_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NSL = WIDTH / SLICE;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a, r_b, r_wsum, r_sum;
    logic             r_carry, r_busy, r_done, r_cout, r_ovf;

    logic             w_capture, w_last, w_slice_c;
    logic [SLICE-1:0] w_slice_a, w_slice_b, w_slice_s;
    logic [WIDTH-1:0] w_wsum_nxt;

    assign w_last    = (r_k == KW'(NSL - 1));
    assign w_capture = start && (r_state == IDLE || r_state == DONE);
    assign w_slice_a = r_a[int'(r_k)*SLICE +: SLICE];
    assign w_slice_b = r_b[int'(r_k)*SLICE +: SLICE];

    nibble_serial_cla_slice #(.SLICE(SLICE)) u_slice (
        .i_a(w_slice_a),
        .i_b(w_slice_b),
        .i_c(r_carry),
        .o_s(w_slice_s),
        .o_c(w_slice_c)
    );

    // The final edge must see the top slice merged into the working sum.
    always_comb begin
        w_wsum_nxt = r_wsum;
        w_wsum_nxt[int'(r_k)*SLICE +: SLICE] = w_slice_s;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_wsum  <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
            if (w_capture) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_k     <= '0;
                r_wsum  <= '0;
            end else if (r_state == RUN) begin
                r_wsum  <= w_wsum_nxt;
                r_carry <= w_slice_c;
                r_k     <= w_last ? '0 : r_k + KW'(1);
                if (w_last) begin
                    r_sum  <= w_wsum_nxt;
                    r_cout <= w_slice_c;
                    r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                              (w_wsum_nxt[WIDTH-1] != r_a[WIDTH-1]);
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;
endmodule
